// File: rtl/axi_mem_responder.sv
// AXI4 subordinate over a byte-addressable dual-ported array; independent write and read burst FSMs.
// Optional AXI_MEM_RAND_STALL_EN adds LFSR-driven backpressure on W, B and R.
module axi_mem_responder #(
    parameter int AxiDataWidth = 64,
    parameter int AxiAddrWidth = 32,
    parameter int AxiIdWidth   = 4,
    parameter int MemBytes     = 65536
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AxiIdWidth-1:0]     ar_id_i,
    input  logic [AxiAddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic [1:0]                ar_burst_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [AxiIdWidth-1:0]     r_id_o,
    output logic [AxiDataWidth-1:0]   r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o
);
    localparam int NB    = AxiDataWidth / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int MEMW  = $clog2(MemBytes);
    localparam int WORDS = MemBytes / NB;
    localparam logic [2:0] MAX_SIZE    = 3'(OFFW);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [AxiDataWidth-1:0] mem [WORDS];

    // WRAP/reserved bursts, oversize beats and out-of-range addresses all fail the beat
    function automatic logic beat_err(input logic [AxiAddrWidth-1:0] addr,
                                      input logic [2:0] size, input logic [1:0] burst);
        return burst[1] || (size > MAX_SIZE) || (|addr[AxiAddrWidth-1:MEMW]);
    endfunction

    function automatic logic [AxiAddrWidth-1:0] beat_step(input logic [2:0] size,
                                                          input logic [1:0] burst);
        return (burst == BURST_INCR) ? (AxiAddrWidth'(1) << size) : '0;
    endfunction

    logic init_q;
    logic w_gate, v_gate;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) init_q <= 1'b0;
        else         init_q <= 1'b1;
    end

`ifdef AXI_MEM_RAND_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= 16'hACE1;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign w_gate = ~lfsr_q[0];
    assign v_gate = ~lfsr_q[1];
`else
    assign w_gate = 1'b1;
    assign v_gate = 1'b1;
`endif

    // ---------------- write channel ----------------
    w_state_e                w_state_q, w_state_d;
    logic [AxiIdWidth-1:0]   w_id_q;
    logic [AxiAddrWidth-1:0] w_addr_q;
    logic [7:0]              w_len_q, w_cnt_q;
    logic [2:0]              w_size_q;
    logic [1:0]              w_burst_q;
    logic                    w_err_q, b_vis_q;
    logic                    aw_fire, w_fire, w_beat_err, w_is_last;

    assign aw_fire    = aw_valid_i && aw_ready_o;
    assign w_fire     = w_valid_i && w_ready_o;
    assign w_beat_err = beat_err(w_addr_q, w_size_q, w_burst_q);
    assign w_is_last  = (w_cnt_q == w_len_q);
    assign b_id_o     = w_id_q;
    assign b_resp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = init_q;
                if (aw_valid_i && init_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready_o = w_gate;
                if (w_valid_i && w_gate && w_is_last) w_state_d = W_RESP;
            end
            W_RESP: begin
                // once raised, valid holds until the handshake
                b_valid_o = b_vis_q || v_gate;
                if (b_valid_o && b_ready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            b_vis_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            b_vis_q   <= b_valid_o && !b_ready_i;
            if (aw_fire) begin
                w_id_q    <= aw_id_i;
                w_addr_q  <= aw_addr_i;
                w_len_q   <= aw_len_i;
                w_size_q  <= aw_size_i;
                w_burst_q <= aw_burst_i;
                w_cnt_q   <= '0;
                w_err_q   <= 1'b0;
            end else if (w_fire) begin
                w_err_q  <= w_err_q | w_beat_err | (w_last_i != w_is_last);
                w_cnt_q  <= w_cnt_q + 8'd1;
                w_addr_q <= w_addr_q + beat_step(w_size_q, w_burst_q);
            end
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_fire && !w_beat_err) begin
            for (int b = 0; b < NB; b++) begin
                if (w_strb_i[b]) mem[w_addr_q[MEMW-1:OFFW]][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e                r_state_q, r_state_d;
    logic [AxiAddrWidth-1:0] r_addr_q, rd_addr;
    logic [7:0]              r_len_q, r_cnt_q;
    logic [2:0]              r_size_q;
    logic [1:0]              r_burst_q;
    logic                    r_vis_q, ar_fire, r_fire, rd_err;
    logic [AxiDataWidth-1:0] rd_word;

    assign ar_fire = ar_valid_i && ar_ready_o;
    assign r_fire  = r_valid_o && r_ready_i;
    // address of the beat to load next: beat 0 from AR, otherwise the successor of the current beat
    assign rd_addr = (r_state_q == R_IDLE) ? ar_addr_i
                                           : r_addr_q + beat_step(r_size_q, r_burst_q);
    assign rd_err  = (r_state_q == R_IDLE) ? beat_err(ar_addr_i, ar_size_i, ar_burst_i)
                                           : beat_err(rd_addr, r_size_q, r_burst_q);
    assign rd_word = mem[rd_addr[MEMW-1:OFFW]];

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_o = init_q;
                if (ar_valid_i && init_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_valid_o = r_vis_q || v_gate;
                if (r_valid_o && r_ready_i && r_last_o) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_vis_q   <= 1'b0;
            r_id_o    <= '0;
            r_data_o  <= '0;
            r_resp_o  <= '0;
            r_last_o  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_vis_q   <= r_valid_o && !r_ready_i;
            if (ar_fire) begin
                r_id_o    <= ar_id_i;
                r_addr_q  <= ar_addr_i;
                r_len_q   <= ar_len_i;
                r_size_q  <= ar_size_i;
                r_burst_q <= ar_burst_i;
                r_cnt_q   <= '0;
                r_last_o  <= (ar_len_i == 8'd0);
                r_data_o  <= rd_err ? '0 : rd_word;
                r_resp_o  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_fire && !r_last_o) begin
                r_addr_q <= rd_addr;
                r_cnt_q  <= r_cnt_q + 8'd1;
                r_last_o <= ((r_cnt_q + 8'd1) == r_len_q);
                r_data_o <= rd_err ? '0 : rd_word;
                r_resp_o <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed vector table, hand-written burst corner cases,
// and randomized write/read bursts checked against a byte-array memory model.
module tb_axi_mem_responder;
    localparam int BUDGET = 300;
    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        aw_valid_i, aw_ready_o;
    logic [3:0]  aw_id_i;
    logic [31:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [2:0]  aw_size_i;
    logic [1:0]  aw_burst_i;
    logic        w_valid_i, w_ready_o;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [3:0]  ar_id_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic        r_valid_o, r_ready_i;
    logic [3:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;

    axi_mem_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd [256];
    logic [1:0]  rr [256];
    logic        rl [256];
    logic [7:0]  mdl [65536];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] base;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
        logic [63:0] exp_rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tmo(input string name);
        n_total++;
        $display("FAIL timeout %s: got no handshake, expected one within %0d cycles", name, BUDGET);
    endtask

    function automatic logic [63:0] mword(input logic [31:0] a);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = mdl[{a[15:3], 3'b000} + b];
        return w;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int early_last,
                            input int nsend, input bit gaps,
                            output logic [3:0] bid, output logic [1:0] bresp);
        int n;
        int nbeats;
        bid = '0;
        bresp = 2'b11;
        nbeats = (nsend < 0) ? int'(len) + 1 : nsend;
        @(negedge clk_i);
        aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr;
        aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
        n = 0;
        while (!aw_ready_o && n < BUDGET) begin @(negedge clk_i); n++; end
        if (n >= BUDGET) begin aw_valid_i = 1'b0; tmo("aw_ready"); return; end
        @(negedge clk_i);
        aw_valid_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
            w_valid_i = 1'b1; w_data_i = wd[i]; w_strb_i = ws[i];
            w_last_i = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            n = 0;
            while (!w_ready_o && n < BUDGET) begin @(negedge clk_i); n++; end
            if (n >= BUDGET) begin w_valid_i = 1'b0; tmo("w_ready"); return; end
            @(negedge clk_i);
            w_valid_i = 1'b0;
            w_last_i = 1'b0;
        end
        if (nsend >= 0) return;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_i);
        b_ready_i = 1'b1;
        n = 0;
        while (!b_valid_o && n < BUDGET) begin @(negedge clk_i); n++; end
        if (n >= BUDGET) begin b_ready_i = 1'b0; tmo("b_valid"); return; end
        bid = b_id_o;
        bresp = b_resp_o;
        @(negedge clk_i);
        b_ready_i = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit gaps,
                           input int hold, input logic [63:0] hold_exp,
                           output int nb, output logic [3:0] rid);
        int n;
        nb = 0;
        rid = '0;
        @(negedge clk_i);
        ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr;
        ar_len_i = len; ar_size_i = size; ar_burst_i = burst;
        n = 0;
        while (!ar_ready_o && n < BUDGET) begin @(negedge clk_i); n++; end
        if (n >= BUDGET) begin ar_valid_i = 1'b0; tmo("ar_ready"); return; end
        @(negedge clk_i);
        ar_valid_i = 1'b0;
        if (hold > 0) begin
            r_ready_i = 1'b0;
            n = 0;
            while (!r_valid_o && n < BUDGET) begin @(negedge clk_i); n++; end
            if (n >= BUDGET) begin tmo("r_valid"); return; end
            for (int k = 0; k < hold; k++) begin
                @(negedge clk_i);
                chk("r_hold_valid", 64'(r_valid_o), 64'd1);
                chk("r_hold_data", r_data_o, hold_exp);
                chk("r_hold_last", 64'(r_last_o), 64'd0);
            end
        end
        n = 0;
        while (n < BUDGET) begin
            r_ready_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (r_valid_o && r_ready_i) begin
                rd[nb] = r_data_o; rr[nb] = r_resp_o; rl[nb] = r_last_o;
                rid = r_id_o;
                nb++;
                if (r_last_o || nb == 256) break;
            end
            @(negedge clk_i);
            n++;
        end
        if (n >= BUDGET) tmo("r_last");
        @(negedge clk_i);
        r_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  bid, rid, id;
        logic [1:0]  bresp, burst;
        logic [31:0] addr, a;
        logic [7:0]  len;
        logic [2:0]  size;
        int          nb, sel;
        bit          err;

        vecs[0] = '{32'h40, 3'd3, INCR, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, OKAY, OKAY, 64'hAAAA_AAAA_FFFF_FFFF};
        vecs[1] = '{32'h48, 3'd3, INCR, 64'h0, 64'h1122_3344_5566_7788, 8'hF0, OKAY, OKAY, 64'h1122_3344_0000_0000};
        vecs[2] = '{32'h50, 3'd3, INCR, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, OKAY, OKAY, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{32'h58, 3'd2, INCR, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, OKAY, OKAY, 64'h0000_0000_CAFE_F00D};
        vecs[4] = '{32'h60, 3'd3, WRAP, 64'h5555_5555_5555_5555, 64'h0, 8'hFF, SLVERR, OKAY, 64'h5555_5555_5555_5555};
        vecs[5] = '{32'h68, 3'd4, INCR, 64'h6666_6666_6666_6666, 64'h0, 8'hFF, SLVERR, OKAY, 64'h6666_6666_6666_6666};
        vecs[6] = '{32'h70, 3'd3, 2'd3, 64'h7777_7777_7777_7777, 64'h0, 8'hFF, SLVERR, OKAY, 64'h7777_7777_7777_7777};
        vecs[7] = '{32'h10000, 3'd3, INCR, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, SLVERR, SLVERR, 64'h0};
        vecs[8] = '{32'hFFF8, 3'd3, INCR, 64'h0, 64'h0BAD_F00D_1234_5678, 8'hFF, OKAY, OKAY, 64'h0BAD_F00D_1234_5678};

        rst_ni = 1'b0;
        aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
        w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
        r_ready_i = 0;

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_aw_ready", 64'(aw_ready_o), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
        chk("rst_w_ready", 64'(w_ready_o), 64'd0);
        chk("rst_b_valid", 64'(b_valid_o), 64'd0);
        chk("rst_r_valid", 64'(r_valid_o), 64'd0);
        chk("rst_r_data", r_data_o, 64'd0);
        chk("rst_r_last", 64'(r_last_o), 64'd0);
        chk("rst_b_resp", 64'(b_resp_o), 64'd0);
        rst_ni = 1'b1;
        #1 chk("init_aw_ready_before_edge", 64'(aw_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("init_aw_ready", 64'(aw_ready_o), 64'd1);
        chk("init_ar_ready", 64'(ar_ready_o), 64'd1);

        // vector table: prefill word, partial/errored write, full-word read back
        for (int v = 0; v < 9; v++) begin
            wd[0] = vecs[v].base; ws[0] = 8'hFF;
            do_write(4'd1, vecs[v].addr, 8'd0, 3'd3, INCR, -1, -1, 1'b0, bid, bresp);
            wd[0] = vecs[v].data; ws[0] = vecs[v].strb;
            do_write(4'd2, vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, -1, -1, 1'b0, bid, bresp);
            chk($sformatf("vec%0d_bresp", v), 64'(bresp), 64'(vecs[v].exp_bresp));
            do_read(4'd3, vecs[v].addr, 8'd0, 3'd3, INCR, 1'b0, 0, 64'd0, nb, rid);
            chk($sformatf("vec%0d_nbeats", v), 64'(nb), 64'd1);
            chk($sformatf("vec%0d_rdata", v), rd[0], vecs[v].exp_rdata);
            chk($sformatf("vec%0d_rresp", v), 64'(rr[0]), 64'(vecs[v].exp_rresp));
            chk($sformatf("vec%0d_rlast", v), 64'(rl[0]), 64'd1);
        end

        // INCR burst of four
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        do_write(4'd3, 32'h100, 8'd3, 3'd3, INCR, -1, -1, 1'b0, bid, bresp);
        chk("t1_bid", 64'(bid), 64'd3);
        chk("t1_bresp", 64'(bresp), 64'(OKAY));
        do_read(4'd3, 32'h100, 8'd3, 3'd3, INCR, 1'b0, 0, 64'd0, nb, rid);
        chk("t1_nbeats", 64'(nb), 64'd4);
        chk("t1_rid", 64'(rid), 64'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_rdata%0d", i), rd[i], 64'(i + 1));
            chk($sformatf("t1_rlast%0d", i), 64'(rl[i]), 64'(i == 3));
        end

        // read running off the end of memory
        do_read(4'd7, 32'hFFF8, 8'd1, 3'd3, INCR, 1'b0, 0, 64'd0, nb, rid);
        chk("t3_nbeats", 64'(nb), 64'd2);
        chk("t3_rdata0", rd[0], 64'h0BAD_F00D_1234_5678);
        chk("t3_rresp0", 64'(rr[0]), 64'(OKAY));
        chk("t3_rlast0", 64'(rl[0]), 64'd0);
        chk("t3_rdata1", rd[1], 64'd0);
        chk("t3_rresp1", 64'(rr[1]), 64'(SLVERR));
        chk("t3_rlast1", 64'(rl[1]), 64'd1);

        // early w_last: both beats still accepted, burst flagged
        wd[0] = 64'hAB; wd[1] = 64'hCD; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(4'd5, 32'h400, 8'd1, 3'd3, INCR, 0, -1, 1'b0, bid, bresp);
        chk("t4_bid", 64'(bid), 64'd5);
        chk("t4_bresp", 64'(bresp), 64'(SLVERR));

        // backpressure on a len=7 read
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h500 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'd6, 32'h200, 8'd7, 3'd3, INCR, -1, -1, 1'b0, bid, bresp);
        do_read(4'd6, 32'h200, 8'd7, 3'd3, INCR, 1'b0, 5, 64'h500, nb, rid);
        chk("t5_nbeats", 64'(nb), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_rdata%0d", i), rd[i], 64'h500 + 64'(i));

        // reset in the middle of a write burst
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hC0DE_0000 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'd9, 32'h300, 8'd3, 3'd3, INCR, -1, 2, 1'b0, bid, bresp);
        w_valid_i = 1'b1; w_data_i = wd[2]; w_strb_i = 8'hFF;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_b_valid", 64'(b_valid_o), 64'd0);
        chk("t6_rst_aw_ready", 64'(aw_ready_o), 64'd0);
        repeat (2) @(negedge clk_i);
        w_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_aw_ready", 64'(aw_ready_o), 64'd1);
        repeat (3) @(negedge clk_i);
        chk("t6_b_valid", 64'(b_valid_o), 64'd0);
        do_read(4'd9, 32'h300, 8'd1, 3'd3, INCR, 1'b0, 0, 64'd0, nb, rid);
        chk("t6_nbeats", 64'(nb), 64'd2);
        chk("t6_rdata0", rd[0], 64'hC0DE_0000);
        chk("t6_rdata1", rd[1], 64'hC0DE_0001);

        // random bursts against the byte model; seed region 0x2000-0x2FFF first
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
            addr = 32'h2000 + 32'(blk * 2048);
            do_write(4'd0, addr, 8'd255, 3'd3, INCR, -1, -1, 1'b0, bid, bresp);
            for (int i = 0; i < 256; i++)
                for (int b = 0; b < 8; b++) mdl[int'(addr) + 8*i + b] = wd[i][8*b +: 8];
        end
        for (int t = 0; t < 40; t++) begin
            id    = 4'($urandom);
            addr  = 32'h2000 + 32'($urandom_range(0, 32'hE00));
            len   = 8'($urandom_range(0, 7));
            size  = 3'($urandom_range(0, 3));
            sel   = $urandom_range(0, 9);
            burst = (sel == 0) ? WRAP : (sel < 4) ? FIXED : INCR;
            for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            do_write(id, addr, len, size, burst, -1, -1, 1'b1, bid, bresp);
            err = (burst == WRAP);
            a = addr;
            for (int i = 0; i <= int'(len); i++) begin
                if (!err)
                    for (int b = 0; b < 8; b++)
                        if (ws[i][b]) mdl[{a[15:3], 3'b000} + b] = wd[i][8*b +: 8];
                if (burst == INCR) a = a + (32'd1 << size);
            end
            chk("rnd_bid", 64'(bid), 64'(id));
            chk("rnd_bresp", 64'(bresp), err ? 64'(SLVERR) : 64'(OKAY));
            do_read(id, addr, len, size, burst, 1'b1, 0, 64'd0, nb, rid);
            chk("rnd_nbeats", 64'(nb), 64'(len) + 64'd1);
            chk("rnd_rid", 64'(rid), 64'(id));
            a = addr;
            for (int i = 0; i < nb && i <= int'(len); i++) begin
                chk("rnd_rdata", rd[i], err ? 64'd0 : mword(a));
                chk("rnd_rresp", 64'(rr[i]), err ? 64'(SLVERR) : 64'(OKAY));
                chk("rnd_rlast", 64'(rl[i]), 64'(i == int'(len)));
                if (burst == INCR) a = a + (32'd1 << size);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
